// File: rtl/buffer_wr_ctrl.sv
// Write-port controller for the frame buffer: round-robin arbitration of two
// pixel writers onto the single write port, plus a full-buffer clear engine.
module buffer_wr_ctrl #(
  parameter int            AW      = 15,
  parameter int            DW      = 3,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;     // 1: requester 1 was granted most recently
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          grant0, grant1, arb_open;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    // On contention the requester not served last wins.
    grant0   = req0_valid & (~req1_valid | last_q);
    grant1   = req1_valid & (~req0_valid | ~last_q);
    // Readies are held low in reset so nothing is handed over while flops are cleared.
    arb_open = reset & (state_q == ARB) & ~clear_start;
    req0_ready = arb_open & grant0;
    req1_ready = arb_open & grant1;

    unique case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (req0_ready) begin
          addr_d = req0_addr;
          data_d = req0_data;
          we_d   = 1'b1;
          last_d = 1'b0;
        end else if (req1_ready) begin
          addr_d = req1_addr;
          data_d = req1_data;
          we_d   = 1'b1;
          last_d = 1'b1;
        end
      end
      CLEAR: begin
        addr_d = cnt_q;
        data_d = CLR_VAL;
        we_d   = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = we_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_buffer_wr_ctrl.sv
// Self-checking bench for buffer_wr_ctrl: a scoreboard of expected buffer
// writes (cycle, address, data, done flag) compared by a write-port monitor.
module tb_buffer_wr_ctrl;

  localparam int            AW   = 4;
  localparam int            DW   = 3;
  localparam logic [DW-1:0] CVAL = 3'b101;
  localparam int            NPOS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, clear_start;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready, clear_busy, clear_done, regwrite;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_total  = 0;
  int   n_pass   = 0;
  bit   exp_last = 1'b1;
  int   step_cyc;

  buffer_wr_ctrl #(.AW(AW), .DW(DW), .CLR_VAL(CVAL)) dut (
    .clk(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .addr_in(addr_in), .data_in(data_in), .regwrite(regwrite)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor: every write must match the scoreboard head in its cycle.
  always @(negedge clk) begin
    if (rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_total++;
        $display("FAIL missing_write: cycle %0d got no write, expected addr %0d data %0d at cycle %0d",
                 cyc, sb[0].addr, sb[0].data, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (regwrite) begin
        n_total++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          $display("FAIL unexpected_write: cycle %0d addr %0d data %0d done %0b, none expected",
                   cyc, addr_in, data_in, clear_done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({addr_in, data_in, clear_done} !== {e.addr, e.data, e.done})
            $display("FAIL write_content: cycle %0d got addr %0d data %0d done %0b, expected addr %0d data %0d done %0b",
                     cyc, addr_in, data_in, clear_done, e.addr, e.data, e.done);
          else n_pass++;
        end
      end else if (clear_done !== 1'b0) begin
        n_total++;
        $display("FAIL stray_done: cycle %0d clear_done=%0b without a write, expected 0", cyc, clear_done);
      end
    end
  end

  task automatic push_exp(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d; e.done = dn;
    sb.push_back(e);
  endtask

  // One clock cycle of stimulus; checks readies and clear_busy against the model.
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic cs, input bit arb, input bit exp_busy, input string tag);
    bit g0, g1, e0, e1;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clear_start = cs;
    step_cyc = cyc;
    #2;
    g0 = v0 && (!v1 || exp_last);
    g1 = v1 && (!v0 || !exp_last);
    e0 = arb && !cs && g0;
    e1 = arb && !cs && g1;
    n_total++;
    if ({req0_ready, req1_ready} !== {e0, e1})
      $display("FAIL %s_ready: cycle %0d ready0/1=%b%b, expected %b%b", tag, cyc, req0_ready, req1_ready, e0, e1);
    else n_pass++;
    n_total++;
    if (clear_busy !== exp_busy)
      $display("FAIL %s_busy: cycle %0d clear_busy=%b, expected %b", tag, cyc, clear_busy, exp_busy);
    else n_pass++;
    if (e0) begin push_exp(cyc + 1, a0, d0, 1'b0); exp_last = 1'b0; end
    if (e1) begin push_exp(cyc + 1, a1, d1, 1'b0); exp_last = 1'b1; end
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    n_total++;
    if ({regwrite, addr_in, data_in, clear_busy, clear_done, req0_ready, req1_ready} !== '0)
      $display("FAIL %s: we=%b addr=%0d data=%0d busy=%b done=%b rdy=%b%b, expected all 0",
               tag, regwrite, addr_in, data_in, clear_busy, clear_done, req0_ready, req1_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      req0_valid = 1'($urandom); req0_addr = AW'($urandom); req0_data = DW'($urandom);
      req1_valid = 1'($urandom); req1_addr = AW'($urandom); req1_data = DW'($urandom);
      clear_start = 1'($urandom);
      #2;
      check_outputs_zero("reset_outputs");
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 3'd2;
    req1_valid = 1'b0; clear_start = 1'b0;
    rst = 1'b1;
    #2;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL reset_release_ready: ready0/1=%b%b, expected 10", req0_ready, req1_ready);
    else n_pass++;
    exp_last = 1'b1;
    push_exp(cyc + 1, 4'd9, 3'd2, 1'b0);
    exp_last = 1'b0;
  endtask

  task automatic test_single();
    step(1'b0, '0, '0, 1'b1, 4'd5, 3'b110, 1'b0, 1'b1, 1'b0, "single_req1");
    idle("single_idle");
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++)
      step(1'b1, AW'(2 * i), DW'(i), 1'b1, AW'(2 * i + 8), DW'(7 - i), 1'b0, 1'b1, 1'b0, "contention");
    idle("contention_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(12 + i), DW'(i + 4), 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "b2b_req0");
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, '0, 1'b1, AW'(i + 1), DW'(6 - i), 1'b0, 1'b1, 1'b0, "b2b_req1");
    idle("b2b_idle");
  endtask

  // Full clear with req0 pending throughout; optional extra start mid-clear.
  task automatic run_clear(input bit extra_start, input string tag);
    int t;
    step(1'b1, 4'd3, 3'd1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, tag);
    t = step_cyc;
    for (int i = 0; i < NPOS; i++)
      push_exp(t + 2 + i, AW'(i), CVAL, (i == NPOS - 1));
    for (int i = 0; i < NPOS; i++)
      step(1'b1, 4'd3, 3'd1, 1'b0, '0, '0, extra_start && (i == 5), 1'b0, 1'b1, tag);
    step(1'b1, 4'd3, 3'd1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, tag);
    idle("clear_idle");
  endtask

  task automatic test_clear();
    run_clear(1'b0, "clear");
  endtask

  task automatic test_reset_mid_clear();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "midclr_start");
    for (int i = 0; i < NPOS; i++)
      push_exp(step_cyc + 2 + i, AW'(i), CVAL, (i == NPOS - 1));
    for (int i = 0; i < 8; i++)
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "midclr_run");
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    check_outputs_zero("midclr_reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_last = 1'b1;
    for (int i = 0; i < 3; i++) idle("midclr_after");
  endtask

  task automatic test_ignored_start();
    run_clear(1'b1, "ignored_start");
  endtask

  initial begin
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    clear_start = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_ignored_start();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d writes still outstanding, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
